rf_write_sched: RTL and testbench
=================================

RF_WRITE_SCHED -- requirements
Module: rf_write_sched

Interface
REQ-001 The block SHALL have parameters: DATA_W, 32, write data width; ADDR_W, 5, register address width (32 registers).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  3  per-requester write request (bit 0 ALU, bit 1 LSU, bit 2 MDU).
REQ-005 req_ready  output  3  per-requester grant; a transfer occurs when req_valid[i] and req_ready[i] are both high at posedge.
REQ-006 req_addr0/1/2  input  ADDR_W each  destination register per requester.
REQ-007 req_data0/1/2  input  DATA_W each  write data per requester.
REQ-008 rsv_valid, rsv_addr  input  1, ADDR_W  issue-stage reservation of a destination register.
REQ-009 chk_addr1, chk_addr2  input  ADDR_W each  source registers to hazard-check.
REQ-010 chk_busy1, chk_busy2  output  1 each  source register has an outstanding write.
REQ-011 rf_we, rf_waddr, rf_wdata  output  1, ADDR_W, DATA_W  register file write port 1.
REQ-012 rf_we2, rf_waddr2, rf_wdata2  output  1, ADDR_W, DATA_W  register file write port 2.
REQ-013 coll_cnt  output  8  saturating count of same-address collisions.

Function
REQ-014 req_ready SHALL be combinational from req_valid, req_addr*, and rr_ptr; at most two bits high per cycle.
REQ-015 Candidates SHALL be scanned in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); the first valid requester is grant A, the next valid one whose address differs from A's is grant B.
REQ-016 A valid requester skipped because its address equals grant A's address SHALL be a collision: ready low that cycle, coll_cnt incremented by one, saturating at 255; at most one increment per cycle.
REQ-017 Grant A SHALL drive port 1 and grant B port 2, registered: rf_we/rf_we2 high exactly one cycle after the handshake cycle, with the captured address and data.
REQ-018 A handshake to address 0 SHALL be accepted (ready high), but the corresponding rf_we/rf_we2 SHALL stay low; it is not a collision source.
REQ-019 Cycles with no handshake SHALL drive rf_we=rf_we2=0; waddr/wdata hold their last values.
REQ-020 rr_ptr (2 bits, values 0..2) SHALL advance to (index of last granted requester + 1) mod 3 after any handshake cycle; unchanged otherwise.
REQ-021 Requesters SHALL hold addr/data stable while valid and not ready; the block does not buffer unaccepted requests.
REQ-022 Scoreboard pending[31:0]: rsv_valid sets pending[rsv_addr]; a write handshake clears pending[addr]; same-address set and clear in one cycle SHALL leave the bit set; pending[0] SHALL be constantly 0.
REQ-023 chk_busyN SHALL equal pending[chk_addrN] OR (rf_we and rf_waddr==chk_addrN) OR (rf_we2 and rf_waddr2==chk_addrN), combinationally; chk_addrN==0 SHALL give 0.
REQ-024 A reservation of an already-pending register SHALL keep it pending; no count of outstanding writes per register is kept.
REQ-025 The block SHALL never drive rf_we and rf_we2 high in the same cycle with equal addresses.

Reset
REQ-026 While rst_n is low: req_ready=0, rf_we=rf_we2=0, rf_waddr/rf_waddr2/rf_wdata/rf_wdata2=0, pending=0, rr_ptr=0, coll_cnt=0, chk_busy1/2=0.
REQ-027 Reset asserted mid-operation SHALL immediately drop any registered write; no rf_we pulse SHALL follow reset release without a new handshake.
REQ-028 The first posedge after rst_n rises SHALL behave as a normal cycle with rr_ptr=0.

Verification
REQ-029 All three valid, addrs 5/6/7, rr_ptr=0 -> ready=011; next cycle rf_we=1 waddr=5, rf_we2=1 waddr2=6; rr_ptr=2.
REQ-030 ALU and LSU both valid to addr 9, MDU idle, rr_ptr=0 -> ready=001, coll_cnt=1; next cycle LSU granted alone, rf_waddr=9.
REQ-031 rsv_valid addr 12, then LSU write to 12 -> chk_busy1 (chk_addr1=12) high from the reservation until the cycle after rf_we pulses with waddr 12, then low.
REQ-032 ALU write to addr 0 with data 0xDEADBEEF -> ready high, rf_we stays 0, chk_busy for addr 0 always 0.
REQ-033 Handshake at cycle N, rst_n low during cycle N+1 -> rf_we=0 throughout, pending=0 and coll_cnt=0 after release.
REQ-034 Repeated ALU/LSU collisions to addr 3 for 300 cycles -> coll_cnt saturates at 255.

Source files
------------

// File: rtl/rf_write_sched.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_sched
// Purpose  : Register-file write scheduler. Picks up to two of three write
//            requesters (ALU, LSU, MDU) per cycle in round-robin order, drives
//            two registered register-file write ports, keeps a pending-write
//            scoreboard for hazard checks and counts same-address collisions.
// Ports    : clk, rst_n               - clock, async active-low reset
//            req_valid/req_ready[2:0] - per-requester handshake (0 ALU,1 LSU,2 MDU)
//            req_addrN/req_dataN      - destination register / data per requester
//            rsv_valid/rsv_addr       - issue-stage destination reservation
//            chk_addrN/chk_busyN      - source hazard check (N = 1, 2)
//            rf_we/rf_waddr/rf_wdata  - register file write port 1
//            rf_we2/rf_waddr2/rf_wdata2 - register file write port 2
//            coll_cnt                 - saturating same-address collision count
// Revision : 1.0 - initial release
// ============================================================================
module rf_write_sched #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req_valid,
  output logic [2:0]        req_ready,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [DATA_W-1:0] req_data2,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              chk_busy1,
  output logic              chk_busy2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we2,
  output logic [ADDR_W-1:0] rf_waddr2,
  output logic [DATA_W-1:0] rf_wdata2,
  output logic [7:0]        coll_cnt
);

  localparam int c_NREG = 1 << ADDR_W;

  logic [ADDR_W-1:0] w_addr [3];
  logic [DATA_W-1:0] w_data [3];
  logic [1:0]        w_scan_idx [3];

  logic              w_a_found;
  logic              w_b_found;
  logic [1:0]        w_a_idx;
  logic [1:0]        w_b_idx;
  logic              w_coll;
  logic [2:0]        w_grant;
  logic [1:0]        w_last_idx;
  logic [1:0]        w_rr_next;
  logic              w_a_we;
  logic              w_b_we;

  logic [c_NREG-1:0] w_set;
  logic [c_NREG-1:0] w_clr;
  logic [c_NREG-1:0] w_pend_next;

  logic [1:0]        r_rr_ptr;
  logic [c_NREG-1:0] r_pending;
  logic              r_we;
  logic              r_we2;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] r_waddr2;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_wdata2;
  logic [7:0]        r_coll_cnt;

  assign w_addr[0] = req_addr0;
  assign w_addr[1] = req_addr1;
  assign w_addr[2] = req_addr2;
  assign w_data[0] = req_data0;
  assign w_data[1] = req_data1;
  assign w_data[2] = req_data2;

  // Scan order starting at the round-robin pointer.
  always_comb begin
    w_scan_idx[0] = 2'd0;
    w_scan_idx[1] = 2'd1;
    w_scan_idx[2] = 2'd2;
    case (r_rr_ptr)
      2'd1: begin
        w_scan_idx[0] = 2'd1;
        w_scan_idx[1] = 2'd2;
        w_scan_idx[2] = 2'd0;
      end
      2'd2: begin
        w_scan_idx[0] = 2'd2;
        w_scan_idx[1] = 2'd0;
        w_scan_idx[2] = 2'd1;
      end
      default: ;
    endcase
  end

  // Grant A is the first valid requester. Any later valid requester that
  // targets A's (nonzero) register is a collision and is held off; the first
  // one that does not is grant B. Address 0 writes are discarded downstream,
  // so they never conflict with each other.
  always_comb begin
    w_a_found = 1'b0;
    w_b_found = 1'b0;
    w_a_idx   = 2'd0;
    w_b_idx   = 2'd0;
    w_coll    = 1'b0;
    w_grant   = 3'b000;
    for (int j = 0; j < 3; j++) begin
      if (req_valid[w_scan_idx[j]]) begin
        if (!w_a_found) begin
          w_a_found = 1'b1;
          w_a_idx   = w_scan_idx[j];
        end else if ((w_addr[w_scan_idx[j]] == w_addr[w_a_idx]) &&
                     (w_addr[w_a_idx] != '0)) begin
          w_coll = 1'b1;
        end else if (!w_b_found) begin
          w_b_found = 1'b1;
          w_b_idx   = w_scan_idx[j];
        end
      end
    end
    if (w_a_found) w_grant[w_a_idx] = 1'b1;
    if (w_b_found) w_grant[w_b_idx] = 1'b1;
  end

  assign req_ready = rst_n ? w_grant : 3'b000;

  assign w_a_we     = w_a_found && (w_addr[w_a_idx] != '0);
  assign w_b_we     = w_b_found && (w_addr[w_b_idx] != '0);
  assign w_last_idx = w_b_found ? w_b_idx : w_a_idx;
  assign w_rr_next  = (w_last_idx == 2'd2) ? 2'd0 : w_last_idx + 2'd1;

  // Scoreboard: a same-cycle reservation wins over a write clear.
  assign w_set = rsv_valid ? (c_NREG'(1) << rsv_addr) : '0;
  assign w_clr = (w_a_found ? (c_NREG'(1) << w_addr[w_a_idx]) : '0) |
                 (w_b_found ? (c_NREG'(1) << w_addr[w_b_idx]) : '0);
  assign w_pend_next = ((r_pending & ~w_clr) | w_set) & ~c_NREG'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= 2'd0;
      r_pending  <= '0;
      r_we       <= 1'b0;
      r_we2      <= 1'b0;
      r_waddr    <= '0;
      r_waddr2   <= '0;
      r_wdata    <= '0;
      r_wdata2   <= '0;
      r_coll_cnt <= 8'd0;
    end else begin
      r_we      <= w_a_we;
      r_we2     <= w_b_we;
      r_pending <= w_pend_next;
      if (w_a_found) begin
        r_waddr  <= w_addr[w_a_idx];
        r_wdata  <= w_data[w_a_idx];
        r_rr_ptr <= w_rr_next;
      end
      if (w_b_found) begin
        r_waddr2 <= w_addr[w_b_idx];
        r_wdata2 <= w_data[w_b_idx];
      end
      if (w_coll && (r_coll_cnt != 8'hFF)) begin
        r_coll_cnt <= r_coll_cnt + 8'd1;
      end
    end
  end

  // Hazard check also covers writes sitting in the output registers, whose
  // pending bits were already cleared at the handshake.
  assign chk_busy1 = (chk_addr1 != '0) &&
                     (r_pending[chk_addr1] ||
                      (r_we  && (r_waddr  == chk_addr1)) ||
                      (r_we2 && (r_waddr2 == chk_addr1)));
  assign chk_busy2 = (chk_addr2 != '0) &&
                     (r_pending[chk_addr2] ||
                      (r_we  && (r_waddr  == chk_addr2)) ||
                      (r_we2 && (r_waddr2 == chk_addr2)));

  assign rf_we     = r_we;
  assign rf_we2    = r_we2;
  assign rf_waddr  = r_waddr;
  assign rf_waddr2 = r_waddr2;
  assign rf_wdata  = r_wdata;
  assign rf_wdata2 = r_wdata2;
  assign coll_cnt  = r_coll_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_write_sched
// Purpose  : Self-checking bench for rf_write_sched: directed scenarios plus
//            randomized traffic compared against a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_write_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req_valid = 3'b000;
  logic [2:0]  req_ready;
  logic [4:0]  req_addr [3];
  logic [31:0] req_data [3];
  logic        rsv_valid = 1'b0;
  logic [4:0]  rsv_addr = 5'd0;
  logic [4:0]  chk_addr1 = 5'd0;
  logic [4:0]  chk_addr2 = 5'd0;
  logic        chk_busy1, chk_busy2;
  logic        rf_we, rf_we2;
  logic [4:0]  rf_waddr, rf_waddr2;
  logic [31:0] rf_wdata, rf_wdata2;
  logic [7:0]  coll_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit          m_pend [32];
  bit          m_we, m_we2;
  logic [4:0]  m_waddr, m_waddr2;
  logic [31:0] m_wdata, m_wdata2;
  int          m_rr;
  int          m_cnt;
  logic [2:0]  last_ready;

  always #5 clk = ~clk;

  rf_write_sched #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr0 (req_addr[0]),
    .req_addr1 (req_addr[1]),
    .req_addr2 (req_addr[2]),
    .req_data0 (req_data[0]),
    .req_data1 (req_data[1]),
    .req_data2 (req_data[2]),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_busy1 (chk_busy1),
    .chk_busy2 (chk_busy2),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_we2    (rf_we2),
    .rf_waddr2 (rf_waddr2),
    .rf_wdata2 (rf_wdata2),
    .coll_cnt  (coll_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_we = 0; m_we2 = 0;
    m_waddr = '0; m_waddr2 = '0;
    m_wdata = '0; m_wdata2 = '0;
    m_rr = 0; m_cnt = 0;
  endtask

  function automatic bit exp_busy(input logic [4:0] c);
    if (c == 5'd0) return 1'b0;
    return m_pend[c] || (m_we && m_waddr == c) || (m_we2 && m_waddr2 == c);
  endfunction

  // One clock cycle: called at a negedge with inputs already driven.
  task automatic step();
    int q[$];
    int a, b;
    bit coll;
    logic [2:0] er;
    #1;
    if (!rst_n) model_reset();
    a = -1; b = -1; coll = 0; er = 3'b000;
    if (rst_n) begin
      for (int j = 0; j < 3; j++)
        if (req_valid[(m_rr + j) % 3]) q.push_back((m_rr + j) % 3);
      if (q.size() > 0) begin
        a = q[0];
        for (int i = 1; i < q.size(); i++) begin
          if (req_addr[q[i]] == req_addr[a] && req_addr[a] != 5'd0) coll = 1;
          else if (b < 0) b = q[i];
        end
      end
      if (a >= 0) er[a] = 1'b1;
      if (b >= 0) er[b] = 1'b1;
    end
    check("req_ready", 64'(req_ready), 64'(er));
    check("chk_busy1", 64'(chk_busy1), 64'(exp_busy(chk_addr1)));
    check("chk_busy2", 64'(chk_busy2), 64'(exp_busy(chk_addr2)));
    last_ready = er;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_we = 0; m_we2 = 0;
      if (a >= 0) begin
        m_we = (req_addr[a] != 5'd0);
        m_waddr = req_addr[a]; m_wdata = req_data[a];
        m_pend[req_addr[a]] = 1'b0;
        m_rr = ((b >= 0 ? b : a) + 1) % 3;
      end
      if (b >= 0) begin
        m_we2 = (req_addr[b] != 5'd0);
        m_waddr2 = req_addr[b]; m_wdata2 = req_data[b];
        m_pend[req_addr[b]] = 1'b0;
      end
      if (rsv_valid) m_pend[rsv_addr] = 1'b1;
      m_pend[0] = 1'b0;
      if (coll && m_cnt < 255) m_cnt++;
    end
    #1;
    check("rf_we", 64'(rf_we), 64'(m_we));
    check("rf_we2", 64'(rf_we2), 64'(m_we2));
    if (m_we || !rst_n) begin
      check("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
      check("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
    end
    if (m_we2 || !rst_n) begin
      check("rf_waddr2", 64'(rf_waddr2), 64'(m_waddr2));
      check("rf_wdata2", 64'(rf_wdata2), 64'(m_wdata2));
    end
    if (rf_we && rf_we2) check("we_pair_addr_distinct", 64'(rf_waddr != rf_waddr2), 64'd1);
    check("coll_cnt", 64'(coll_cnt), 64'(m_cnt));
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 3'b000; rsv_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin req_addr[i] = '0; req_data[i] = '0; end
    model_reset();
    last_ready = 3'b000;
    @(posedge clk);
    @(negedge clk);

    // Reset state with requests presented: ready must stay low.
    req_valid = 3'b111;
    do_reset();
    check("rst_coll_cnt", 64'(coll_cnt), 64'd0);

    // Three requesters to 5/6/7 from rr_ptr 0.
    req_valid = 3'b111;
    req_addr[0] = 5'd5; req_addr[1] = 5'd6; req_addr[2] = 5'd7;
    req_data[0] = 32'h1111_0005; req_data[1] = 32'h2222_0006; req_data[2] = 32'h3333_0007;
    step();
    check("three_waddr", 64'(rf_waddr), 64'd5);
    check("three_waddr2", 64'(rf_waddr2), 64'd6);
    req_valid = 3'b100;
    step();
    idle();
    step();

    // ALU/LSU collision on register 9.
    do_reset();
    req_valid = 3'b011;
    req_addr[0] = 5'd9; req_addr[1] = 5'd9;
    req_data[0] = 32'hAAAA_0009; req_data[1] = 32'hBBBB_0009;
    step();
    check("coll_first_cnt", 64'(coll_cnt), 64'd1);
    req_valid = 3'b010;
    step();
    check("coll_lsu_waddr", 64'(rf_waddr), 64'd9);
    check("coll_lsu_wdata", 64'(rf_wdata), 64'hBBBB_0009);
    idle();
    step();

    // Reservation then write to register 12.
    do_reset();
    chk_addr1 = 5'd12;
    rsv_valid = 1'b1; rsv_addr = 5'd12;
    step();
    rsv_valid = 1'b0;
    req_valid = 3'b010; req_addr[1] = 5'd12; req_data[1] = 32'h0C0C_0C0C;
    step();
    idle();
    step();
    step();
    check("rsv12_cleared", 64'(chk_busy1), 64'd0);

    // Write to register 0 is accepted but never reaches the port.
    chk_addr1 = 5'd0; chk_addr2 = 5'd0;
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    req_valid = 3'b001; req_addr[0] = 5'd0; req_data[0] = 32'hDEADBEEF;
    step();
    idle();
    step();

    // Reset while a registered write is on the port.
    req_valid = 3'b011; req_addr[0] = 5'd4; req_addr[1] = 5'd4;
    step();
    req_valid = 3'b000; rsv_valid = 1'b1; rsv_addr = 5'd20;
    step();
    rsv_valid = 1'b0;
    req_valid = 3'b001; req_addr[0] = 5'd14;
    step();
    check("pre_rst_we", 64'(rf_we), 64'd1);
    req_valid = 3'b000;
    rst_n = 1'b0;
    #1;
    check("async_rst_we", 64'(rf_we), 64'd0);
    check("async_rst_cnt", 64'(coll_cnt), 64'd0);
    step();
    rst_n = 1'b1;
    chk_addr1 = 5'd20; chk_addr2 = 5'd14;
    step();
    check("post_rst_we", 64'(rf_we), 64'd0);
    check("post_rst_busy", 64'({chk_busy1, chk_busy2}), 64'd0);
    check("post_rst_cnt", 64'(coll_cnt), 64'd0);

    // Sustained collisions on register 3 saturate the counter.
    req_valid = 3'b011; req_addr[0] = 5'd3; req_addr[1] = 5'd3;
    req_data[0] = 32'h0000_0A03; req_data[1] = 32'h0000_0B03;
    for (int n = 0; n < 300; n++) step();
    check("coll_saturate", 64'(coll_cnt), 64'd255);
    idle();
    step();
    do_reset();

    // Randomized traffic honouring the hold-while-not-ready rule.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!(req_valid[i] && !last_ready[i])) begin
          req_valid[i] = ($urandom_range(0, 9) < 6);
          req_addr[i]  = 5'($urandom_range(0, 7));
          req_data[i]  = $urandom;
        end
      end
      rsv_valid = ($urandom_range(0, 3) == 0);
      rsv_addr  = 5'($urandom_range(0, 7));
      chk_addr1 = 5'($urandom_range(0, 7));
      chk_addr2 = 5'($urandom_range(0, 31));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
